bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_countdown_timer.sv | 133 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown timer with prescaled one-second ticks, pause,
// leading-zero blanking enables and a single-cycle expiry pulse.
module bcd_countdown_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        start,
  input  logic        pause,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0,
  output logic        en2,
  output logic        en1,
  output logic        en0,
  output logic        running,
  output logic        done
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [11:0]   digits_reg, digits_next;
  logic          done_reg, done_next;
  logic [11:0]   load_clamped;
  logic [11:0]   dec_val;

  // Out-of-range nibbles saturate to 9 so the held value is always valid BCD.
  for (genvar gi = 0; gi < 3; gi++) begin : g_clamp
    assign load_clamped[gi*4 +: 4] =
      (load_val[gi*4 +: 4] > 4'd9) ? 4'd9 : load_val[gi*4 +: 4];
  end

  // BCD decrement with borrow ones -> tens -> hundreds; 000 is held.
  always_comb begin
    dec_val = digits_reg;
    if (digits_reg != 12'h000) begin
      if (digits_reg[3:0] != 4'd0) begin
        dec_val[3:0] = digits_reg[3:0] - 4'd1;
      end else begin
        dec_val[3:0] = 4'd9;
        if (digits_reg[7:4] != 4'd0) begin
          dec_val[7:4] = digits_reg[7:4] - 4'd1;
        end else begin
          dec_val[7:4]  = 4'd9;
          dec_val[11:8] = digits_reg[11:8] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    digits_next = digits_reg;
    done_next   = 1'b0;
    if (load) begin
      state_next  = IDLE;
      presc_next  = '0;
      digits_next = load_clamped;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && (digits_reg != 12'h000)) begin
            state_next = RUN;
            presc_next = '0;
          end
        end
        RUN: begin
          // A tick coinciding with pause is dropped; the prescaler holds.
          if (pause) begin
            state_next = PAUSED;
          end else if (presc_reg == PMAX) begin
            presc_next  = '0;
            digits_next = dec_val;
            if (dec_val == 12'h000) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_next = RUN;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      presc_reg  <= '0;
      digits_reg <= 12'h000;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      digits_reg <= digits_next;
      done_reg   <= done_next;
    end
  end

  assign d2      = digits_reg[11:8];
  assign d1      = digits_reg[7:4];
  assign d0      = digits_reg[3:0];
  assign en0     = 1'b1;
  assign en1     = (digits_reg[11:8] != 4'd0) || (digits_reg[7:4] != 4'd0);
  assign en2     = (digits_reg[11:8] != 4'd0);
  assign running = (state_reg == RUN);
  assign done    = done_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random stimulus,
// checked every cycle against a decimal-arithmetic reference model.
module tb_bcd_countdown_timer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [11:0] load_val;
  logic        start;
  logic        pause;
  logic [3:0]  d2, d1, d0;
  logic        en2, en1, en0;
  logic        running;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Reference model: remaining seconds as a plain integer.
  int m_val;
  int m_elapsed;
  bit m_counting;
  bit m_paused;
  bit m_expired;
  bit m_done;

  bcd_countdown_timer #(.TICKS_PER_SEC(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .d2       (d2),
    .d1       (d1),
    .d0       (d0),
    .en2      (en2),
    .en1      (en1),
    .en0      (en0),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic int clamp_val(input logic [11:0] v);
    int h, t, o;
    h = int'(v[11:8]);
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (h > 9) h = 9;
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return h * 100 + t * 10 + o;
  endfunction

  task automatic model_reset();
    m_val      = 0;
    m_elapsed  = 0;
    m_counting = 1'b0;
    m_paused   = 1'b0;
    m_expired  = 1'b0;
    m_done     = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (load) begin
      m_val      = clamp_val(load_val);
      m_elapsed  = 0;
      m_counting = 1'b0;
      m_paused   = 1'b0;
      m_expired  = 1'b0;
    end else if (m_counting) begin
      if (m_paused) begin
        if (!pause) m_paused = 1'b0;
      end else if (pause) begin
        m_paused = 1'b1;
      end else begin
        m_elapsed++;
        if (m_elapsed == T) begin
          m_elapsed = 0;
          m_val--;
          if (m_val == 0) begin
            m_counting = 1'b0;
            m_expired  = 1'b1;
            m_done     = 1'b1;
          end
        end
      end
    end else if (!m_expired && start && m_val != 0) begin
      m_counting = 1'b1;
      m_elapsed  = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [11:0] e;
    logic [2:0]  en_e;
    e[11:8] = 4'(m_val / 100);
    e[7:4]  = 4'((m_val / 10) % 10);
    e[3:0]  = 4'(m_val % 10);
    en_e    = {m_val >= 100, m_val >= 10, 1'b1};
    check({tag, "_digits"}, 32'({d2, d1, d0}), 32'(e));
    check({tag, "_en"}, 32'({en2, en1, en0}), 32'(en_e));
    check({tag, "_running"}, 32'(running), 32'(m_counting && !m_paused));
    check({tag, "_done"}, 32'(done), 32'(m_done));
  endtask

  task automatic step(input logic ld, input logic [11:0] lv, input logic st, input logic ps);
    load     = ld;
    load_val = lv;
    start    = st;
    pause    = ps;
    if (ld) $display("txn load %03h start=%0b pause=%0b at %0t", lv, st, ps, $time);
    @(posedge clk);
    model_edge();
    #1;
    compare_all("step");
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  initial begin
    logic pause_level;
    logic [11:0] lv;
    rst = 1'b0; load = 1'b0; load_val = 12'h000; start = 1'b0; pause = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all("reset");
    check("reset_en", 32'({en2, en1, en0}), 32'(3'b001));
    rst = 1'b1;

    // Full countdown from 012 with a single done pulse.
    done_cnt = 0;
    step(1'b1, 12'h012, 1'b0, 1'b0);
    check("load012", 32'({d2, d1, d0}), 32'h012);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    idle_steps(12 * T + 3);
    check("cnt012_done_pulses", 32'(done_cnt), 32'd1);
    check("cnt012_stopped", 32'(running), 32'd0);

    // Borrow across hundreds and tens; leading-zero enables.
    step(1'b1, 12'h100, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    idle_steps(T);
    check("b100_val", 32'({d2, d1, d0}), 32'h099);
    check("b100_en", 32'({en2, en1, en0}), 32'(3'b011));
    idle_steps(90 * T);
    check("b009_val", 32'({d2, d1, d0}), 32'h009);
    check("b009_en", 32'({en2, en1, en0}), 32'(3'b001));

    // Pause spanning a tick, then resume from the held prescaler count.
    step(1'b1, 12'h005, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    idle_steps(2);
    for (int i = 0; i < 10; i++) step(1'b0, 12'h000, 1'b0, 1'b1);
    check("pause_hold", 32'({d2, d1, d0}), 32'h005);
    idle_steps(2);
    check("pause_resume_pre", 32'({d2, d1, d0}), 32'h005);
    idle_steps(1);
    check("pause_resume_tick", 32'({d2, d1, d0}), 32'h004);

    // Clamping and zero-start.
    step(1'b1, 12'h0F3, 1'b0, 1'b0);
    check("clamp_0f3", 32'({d2, d1, d0}), 32'h093);
    done_cnt = 0;
    step(1'b1, 12'h000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 12'h000, 1'b1, 1'b0);
    check("zero_start_running", 32'(running), 32'd0);
    check("zero_start_done", 32'(done_cnt), 32'd0);

    // Asynchronous reset mid-run at 007.
    done_cnt = 0;
    step(1'b1, 12'h009, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    idle_steps(2 * T);
    check("pre_rst_val", 32'({d2, d1, d0}), 32'h007);
    rst = 1'b0;
    $display("txn async reset at %0t", $time);
    #2;
    model_reset();
    compare_all("async_rst");
    check("async_rst_en", 32'({en2, en1, en0}), 32'(3'b001));
    idle_steps(1);
    rst = 1'b1;
    check("rst_no_done", 32'(done_cnt), 32'd0);
    step(1'b1, 12'h003, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    idle_steps(3 * T + 2);
    check("post_rst_done", 32'(done_cnt), 32'd1);

    // Load coincident with a tick wins.
    step(1'b1, 12'h003, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    idle_steps(T - 1);
    step(1'b1, 12'h042, 1'b0, 1'b0);
    check("load_tick_val", 32'({d2, d1, d0}), 32'h042);
    check("load_tick_idle", 32'(running), 32'd0);
    idle_steps(T + 1);
    check("load_tick_hold", 32'({d2, d1, d0}), 32'h042);

    // Random stimulus.
    pause_level = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        $display("txn async reset at %0t", $time);
        #2;
        model_reset();
        compare_all("rnd_rst");
        step(1'b0, 12'h000, 1'($urandom), 1'b0);
        rst = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) pause_level = ~pause_level;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 0) lv = 12'($urandom);
        else lv = {4'h0, 4'($urandom_range(0, 2)), 4'($urandom)};
        step(1'b1, lv, 1'($urandom), pause_level);
      end else begin
        step(1'b0, 12'($urandom), 1'($urandom), pause_level);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
